alu_sequencer: RTL and testbench
================================

# alu_sequencer

Programmable controller for the register-file/ALU datapath. It fetches 16-bit instruction words from a synchronous instruction ROM and decodes each one into the datapath control bundle: one-hot register write enable, A/B read-mux selects, immediate select and ALU control word. It sits between a start/done handshake from the top level and the register file, ALU and mux datapath, and replaces fixed-sequence test controllers with a stored program.

## Interface
- ADDR_W, 8, program counter and ROM address width; legal range 4–8.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start  in  1  begin execution at address 0; sampled only in IDLE.
- flag_z  in  1  registered zero flag from the ALU flag register.
- imem_data  in  16  ROM read data, valid the cycle after imem_addr is presented.
- imem_addr  out  ADDR_W  ROM address (equals pc).
- busy  out  1  high in FETCH, DECODE and EXEC.
- done  out  1  one-cycle pulse when HALT retires.
- RegEnable  out  16  one-hot register write enable; bit n writes rn.
- MuxControlA  out  4  A-operand register select.
- MuxControlB  out  4  B-operand register select.
- MuxControlC  out  1  0 = B from register, 1 = B from immediate.
- AluControl  out  16  instruction word forwarded to the ALU.

## Operation
- Instruction fields: op = [15:12], rd = [11:8], ext = [7:4], rs = [3:0].
- Register class (op = 0000): RegEnable = 1<<rd, MuxA = rd, MuxB = rs, MuxC = 0, AluControl = word.
- Immediate class (op = 0001–1110): RegEnable = 1<<rd, MuxA = rd, MuxB = 0, MuxC = 1, AluControl = word.
- Control class (op = 1111): sub = [11:8], tgt = [7:0], truncated to ADDR_W.
  - sub 0000 is HALT.
  - sub 0001 is NOP.
  - sub 0010 is BZ.
  - sub 0011 is BNZ.
  - Any other sub is NOP.
  - All control-class instructions drive RegEnable = 0, all muxes = 0 and AluControl = 0.
- States:
  - IDLE: start=1 → FETCH with pc = 0. Otherwise stay in IDLE.
  - FETCH: imem_addr = pc → DECODE.
  - DECODE: capture imem_data into the IR. HALT → DONE. Everything else → EXEC. Registered control outputs load on this edge.
  - EXEC: control outputs are valid for exactly this cycle. pc ← branch taken ? tgt : pc+1. Next state FETCH.
  - DONE: done = 1, busy = 0 → IDLE.
- In every state except EXEC, all control outputs are 0.
- pc wraps from 2^ADDR_W−1 to 0 silently.
- start is ignored outside IDLE. start held high through DONE launches a new run from the next IDLE.
- Writes to r0 are permitted; the sequencer does not block them.

## Timing
- Reset values: state IDLE, pc 0, IR 0, busy 0, done 0, all control outputs 0, imem_addr 0.
- reset asserted mid-run aborts at the next edge. No further RegEnable pulse occurs.
- Each non-HALT instruction takes 3 cycles (FETCH, DECODE, EXEC). HALT takes 3 cycles (FETCH, DECODE, DONE).
- Start accepted at edge k: FETCH in cycle k+1, first EXEC in cycle k+3. The register write commits at the end of cycle k+3.
- ROM latency is exactly 1 cycle. imem_addr is stable throughout FETCH and DECODE.
- Branches use flag_z as sampled in the EXEC cycle of the branch. That value reflects the previous ALU instruction. flag_z is not used in any other state.

## Configuration
- SEQ_BRANCH_EN defined: BZ branches when flag_z=1 and BNZ branches when flag_z=0, loading pc ← tgt at the EXEC edge.
- SEQ_BRANCH_EN undefined: sub 0010 and 0011 decode as NOP, and the flag_z input is unused.

## Structure
- Shared package seq_pkg holds:
  - state encoding constants (IDLE, FETCH, DECODE, EXEC, DONE);
  - opcode and field constants (OP_REG = 4'b0000, OP_CTRL = 4'b1111);
  - control sub-op constants (SUB_HALT, SUB_NOP, SUB_BZ, SUB_BNZ).
- Sub-module seq_decode is purely combinational. It maps the IR to {RegEnable, MuxA, MuxB, MuxC, AluControl, is_halt, is_branch}. The top level owns the FSM, pc and output registers.

## Test plan
- Reset then start. ROM[0]=16'h0156 (reg-class, rd=1, rs=6), ROM[1]=16'hF000. Required: RegEnable=16'h0002, MuxA=1, MuxB=6, MuxC=0 in cycle 3 only; done pulses in cycle 6; busy is high in cycles 1–5.
- ROM[0]=16'h1210 (immediate class, rd=2). Required: RegEnable=16'h0004, MuxA=2, MuxC=1, AluControl=16'h1210 in EXEC.
- ROM[0]=16'hF205 (BZ to 5), flag_z=1, SEQ_BRANCH_EN defined. Required: next imem_addr=5 and no RegEnable pulse. With flag_z=0, next imem_addr=1. With SEQ_BRANCH_EN undefined, next imem_addr=1 in both cases.
- Assert reset during the DECODE of ROM[2]. Required: no EXEC follows, all outputs are 0 next cycle, and state is IDLE.
- ADDR_W=4 with a ROM full of NOPs (16'hF100). Required: imem_addr runs 0…15 then 0, busy stays high, done never pulses.
- Pulse start while busy. Required: no effect on pc or state.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the stored-program ALU sequencer.
// Holds the FSM state encoding, instruction opcode/sub-op constants
// and the packed datapath control bundle driven toward the register
// file, operand muxes and ALU.
package seq_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned REG_SEL_W = 4;
  localparam int unsigned NUM_REGS  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [3:0] OP_REG  = 4'b0000;
  localparam logic [3:0] OP_CTRL = 4'b1111;

  localparam logic [3:0] SUB_HALT = 4'b0000;
  localparam logic [3:0] SUB_NOP  = 4'b0001;
  localparam logic [3:0] SUB_BZ   = 4'b0010;
  localparam logic [3:0] SUB_BNZ  = 4'b0011;

  typedef struct packed {
    logic [NUM_REGS-1:0]  reg_en;
    logic [REG_SEL_W-1:0] mux_a;
    logic [REG_SEL_W-1:0] mux_b;
    logic                 mux_c;
    logic [INSTR_W-1:0]   alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder for the ALU sequencer.
// Ports:
//   ir_i             instruction word
//   ctrl_o           datapath control bundle (all zero for control class)
//   is_halt_o        control-class HALT
//   is_branch_o      conditional branch (only with SEQ_BRANCH_EN)
//   branch_on_zero_o branch is BZ (else BNZ)
//   tgt_o            branch target, truncated to ADDR_W
// Optional feature macro: SEQ_BRANCH_EN enables BZ/BNZ; otherwise they are NOPs.
module seq_decode
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [INSTR_W-1:0] ir_i,
  output ctrl_t              ctrl_o,
  output logic               is_halt_o,
  output logic               is_branch_o,
  output logic               branch_on_zero_o,
  output logic [ADDR_W-1:0]  tgt_o
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [3:0] sub;

  assign op  = ir_i[15:12];
  assign rd  = ir_i[11:8];
  assign rs  = ir_i[3:0];
  assign sub = ir_i[11:8];

  // Field decode; unknown control sub-ops fall through as NOP.
  always_comb begin
    ctrl_o           = '0;
    is_halt_o        = 1'b0;
    is_branch_o      = 1'b0;
    branch_on_zero_o = 1'b0;
    tgt_o            = ir_i[ADDR_W-1:0];
    if (op == OP_CTRL) begin
      case (sub)
        SUB_HALT: is_halt_o = 1'b1;
`ifdef SEQ_BRANCH_EN
        SUB_BZ: begin
          is_branch_o      = 1'b1;
          branch_on_zero_o = 1'b1;
        end
        SUB_BNZ: is_branch_o = 1'b1;
`endif
        default: ;
      endcase
    end else begin
      ctrl_o.reg_en   = NUM_REGS'(1) << rd;
      ctrl_o.mux_a    = rd;
      ctrl_o.alu_ctrl = ir_i;
      if (op == OP_REG) begin
        ctrl_o.mux_b = rs;
        ctrl_o.mux_c = 1'b0;
      end else begin
        ctrl_o.mux_b = '0;
        ctrl_o.mux_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Stored-program controller for the register-file/ALU datapath.
// Fetches 16-bit words from a 1-cycle synchronous ROM and issues one
// registered control bundle per instruction (FETCH, DECODE, EXEC).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               launch a run at address 0 (IDLE only)
//   flag_z              ALU zero flag, used by BZ/BNZ in EXEC
//   imem_data/imem_addr ROM read port (addr == pc)
//   busy, done          run status; done pulses when HALT retires
//   RegEnable, MuxControlA/B/C, AluControl  datapath controls (EXEC only)
// Optional feature macro: SEQ_BRANCH_EN (conditional branches).
module alu_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 flag_z,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_REGS-1:0]  RegEnable,
  output logic [REG_SEL_W-1:0] MuxControlA,
  output logic [REG_SEL_W-1:0] MuxControlB,
  output logic                 MuxControlC,
  output logic [INSTR_W-1:0]   AluControl
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  ctrl_t               dec_ctrl;
  logic                dec_halt;
  logic                dec_branch;
  logic                dec_bz;
  logic [ADDR_W-1:0]   dec_tgt;
  logic                take_branch;

  // Decode the word being captured in DECODE so controls register on that edge.
  assign ir_d = (state_q == DECODE) ? imem_data : ir_q;

  seq_decode #(.ADDR_W(ADDR_W)) u_decode (
    .ir_i             (ir_d),
    .ctrl_o           (dec_ctrl),
    .is_halt_o        (dec_halt),
    .is_branch_o      (dec_branch),
    .branch_on_zero_o (dec_bz),
    .tgt_o            (dec_tgt)
  );

`ifdef SEQ_BRANCH_EN
  assign take_branch = dec_branch && (dec_bz ? flag_z : !flag_z);
`else
  logic unused_branch;
  assign unused_branch = ^{flag_z, dec_branch, dec_bz};
  assign take_branch   = 1'b0;
`endif

  // Next-state, pc and control-bundle logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ctrl_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (dec_halt) begin
          state_d = DONE;
        end else begin
          state_d = EXEC;
          ctrl_d  = dec_ctrl;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = take_branch ? dec_tgt : pc_q + ADDR_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FETCH) || (state_d == DECODE) || (state_d == EXEC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr   = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign RegEnable   = ctrl_q.reg_en;
  assign MuxControlA = ctrl_q.mux_a;
  assign MuxControlB = ctrl_q.mux_b;
  assign MuxControlC = ctrl_q.mux_c;
  assign AluControl  = ctrl_q.alu_ctrl;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a program-level reference model
// expands each run into its expected per-cycle output trace; a monitor
// pops and compares whenever the sequencer is busy or signals done.
module tb_alu_sequencer;

`ifdef SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [7:0]  addr;
    logic [15:0] re;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic        mc;
    logic [15:0] alu;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, start, flag_z;
  logic [15:0] imem_data;
  logic [7:0]  imem_addr;
  logic        busy, done;
  logic [15:0] RegEnable, AluControl;
  logic [3:0]  MuxControlA, MuxControlB;
  logic        MuxControlC;

  logic        start4;
  logic [15:0] imem_data4;
  logic [3:0]  imem_addr4;
  logic        busy4, done4;
  logic [15:0] re4, alu4;
  logic [3:0]  ma4, mb4;
  logic        mc4;

  logic [15:0] rom [256];
  obs_t        exp_q[$];
  bit          sb_en = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          done4_cnt = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .flag_z(flag_z),
    .imem_data(imem_data), .imem_addr(imem_addr), .busy(busy), .done(done),
    .RegEnable(RegEnable), .MuxControlA(MuxControlA), .MuxControlB(MuxControlB),
    .MuxControlC(MuxControlC), .AluControl(AluControl)
  );

  assign imem_data4 = 16'hF100;

  alu_sequencer #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .flag_z(1'b0),
    .imem_data(imem_data4), .imem_addr(imem_addr4), .busy(busy4), .done(done4),
    .RegEnable(re4), .MuxControlA(ma4), .MuxControlB(mb4),
    .MuxControlC(mc4), .AluControl(alu4)
  );

  always @(posedge clk) imem_data <= rom[imem_addr];
  always @(posedge clk) if (done4) done4_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic obs_t mk(input logic b, input logic d, input logic [7:0] a,
                              input logic [15:0] w, input bit exec);
    obs_t o;
    o = '0;
    o.busy = b;
    o.done = d;
    o.addr = a;
    if (exec && w[15:12] != 4'hF) begin
      o.re  = 16'd1 << w[11:8];
      o.ma  = w[11:8];
      o.mb  = (w[15:12] == 4'h0) ? w[3:0] : 4'h0;
      o.mc  = (w[15:12] != 4'h0);
      o.alu = w;
    end
    return o;
  endfunction

  // Reference model: walk the program and emit every cycle the run should show.
  function automatic void build_trace(input logic fz);
    int pc = 0;
    for (int n = 0; n < 600; n++) begin
      logic [15:0] w;
      bit taken;
      w = rom[pc];
      exp_q.push_back(mk(1'b1, 1'b0, 8'(pc), w, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b0, 8'(pc), w, 1'b0));
      if (w[15:12] == 4'hF && w[11:8] == 4'h0) begin
        exp_q.push_back(mk(1'b0, 1'b1, 8'(pc), w, 1'b0));
        return;
      end
      exp_q.push_back(mk(1'b1, 1'b0, 8'(pc), w, 1'b1));
      taken = BR_EN && w[15:12] == 4'hF &&
              ((w[11:8] == 4'h2 && fz) || (w[11:8] == 4'h3 && !fz));
      pc = taken ? int'(w[7:0]) : (pc + 1) % 256;
    end
  endfunction

  always @(negedge clk) begin
    if (sb_en) begin
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_activity", 64'({busy, done}), 64'd0);
        end else begin
          obs_t act, e;
          act = '{busy, done, imem_addr, RegEnable, MuxControlA, MuxControlB,
                  MuxControlC, AluControl};
          e = exp_q.pop_front();
          chk("trace", 64'(act), 64'(e));
        end
      end else begin
        chk("idle_ctrl", 64'({RegEnable, MuxControlA, MuxControlB, MuxControlC, AluControl}), 64'd0);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic run_program(input logic fz, input bit mid_start);
    int n = 0;
    flag_z = fz;
    build_trace(fz);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (mid_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      chk("run_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic random_program();
    int len;
    clear_rom();
    len = $urandom_range(2, 12);
    for (int i = 0; i < len; i++) begin
      logic [3:0] op;
      logic [3:0] sub;
      op = 4'($urandom_range(0, 15));
      if (op != 4'hF) begin
        rom[i] = 16'($urandom);
        rom[i][15:12] = op;
      end else begin
        sub = 4'($urandom_range(0, 15));
        if (sub == 4'h2 || sub == 4'h3)
          rom[i] = {4'hF, sub, 8'($urandom_range(i + 1, len))};
        else
          rom[i] = {4'hF, sub, 8'($urandom)};
      end
    end
  endtask

  initial begin
    clear_rom();
    reset = 1'b1; start = 1'b0; start4 = 1'b0; flag_z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({RegEnable, MuxControlA, MuxControlB, MuxControlC, AluControl}), 64'd0);
    chk("reset_status", 64'({busy, done, imem_addr}), 64'd0);
    chk("reset4_status", 64'({busy4, done4, imem_addr4}), 64'd0);
    reset = 1'b0;
    sb_en = 1'b1;
    @(posedge clk); #1;

    // Register class, then HALT.
    clear_rom(); rom[0] = 16'h0156; rom[1] = 16'hF000;
    run_program(1'b0, 1'b0);
    // Immediate class.
    clear_rom(); rom[0] = 16'h1210; rom[1] = 16'hF000;
    run_program(1'b0, 1'b0);
    // BZ to 5 with both flag values.
    clear_rom(); rom[0] = 16'hF205; rom[1] = 16'h0123; rom[2] = 16'hF000; rom[5] = 16'hF000;
    run_program(1'b1, 1'b0);
    run_program(1'b0, 1'b0);
    // BNZ to 4 with both flag values.
    clear_rom(); rom[0] = 16'hF304; rom[1] = 16'h2345; rom[2] = 16'hF000; rom[4] = 16'h0F0E;
    run_program(1'b0, 1'b0);
    run_program(1'b1, 1'b1);

    for (int t = 0; t < 25; t++) begin
      random_program();
      run_program(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset during DECODE of the third instruction aborts the run.
    sb_en = 1'b0;
    clear_rom(); rom[0] = 16'h0311; rom[1] = 16'h0422; rom[2] = 16'h0533;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_decode_addr", 64'(imem_addr), 64'd2);
    chk("abort_decode_re", 64'(RegEnable), 64'd0);
    @(posedge clk); #1;
    chk("abort_ctrl", 64'({RegEnable, MuxControlA, MuxControlB, MuxControlC, AluControl}), 64'd0);
    chk("abort_status", 64'({busy, done, imem_addr}), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_exec", 64'({busy, RegEnable}), 64'd0);
    end
    @(posedge clk); #1;
    sb_en = 1'b1;

    // Narrow pc wraps 15 -> 0 through a NOP-only program.
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("wrap_addr", 64'(imem_addr4), 64'(i % 16));
      chk("wrap_busy", 64'(busy4), 64'd1);
      repeat (3) @(posedge clk);
    end
    chk("wrap_no_done", 64'(done4_cnt), 64'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("wrap_reset", 64'({busy4, imem_addr4}), 64'd0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
